// File: rtl/clic_tb_pkg.sv
// Shared types for the TB instruction-fetch sequencer: XLEN word type, fetch FSM states,
// FIFO entry layout and the bank decode of a 14-bit word address.
package clic_tb_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [31:0]     instruction_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    instruction_t instr;
    xlen_t        pc;
  } fetch_entry_t;

  function automatic logic [1:0] bank_of(input logic [13:0] addr);
    return addr[13:12];
  endfunction

endpackage

// File: rtl/clic_fetch_fifo.sv
// Synchronous FIFO of fetch entries with single-cycle flush and occupancy count.
// Head data reads as zero while empty so idle outputs are clean.
module clic_fetch_fifo
  import clic_tb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               wdata_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output fetch_entry_t               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]         wptr_q, rptr_q;
  logic [CntW-1:0]         count_q;
  logic                    do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign valid_o = (count_q != '0);
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CntW'(push_i) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/clic_fetch_ctrl.sv
// Fetch sequencer: issues word reads, queues responses and hands them to the executor.
// Define CLIC_FETCH_ASSERT_EN to compile in protocol assertions.
module clic_fetch_ctrl
  import clic_tb_pkg::*;
#(
  parameter logic [13:0] BOOT_ADDR  = 14'h0000,
  parameter logic [13:0] MTVEC_BASE = 14'h1000,
  parameter logic [13:0] STVEC_BASE = 14'h2000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic         trap_i,
  input  logic         trap_smode_i,
  input  logic         redirect_i,
  input  xlen_t        redirect_pc_i,
  output xlen_t        mem_addr_o,
  input  instruction_t mem_rdata_i,
  output logic         instr_valid_o,
  input  logic         instr_ready_i,
  output instruction_t instr_o,
  output xlen_t        instr_pc_o,
  output logic         busy_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q;
  logic [13:0]     pc_q, last_q, target;
  logic            req_q;
  logic            flush, credit_ok, bank_hold, issue, push, pop;
  logic [CntW-1:0] count;
  fetch_entry_t    wentry, head;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[XLEN-1:14];

  assign flush  = trap_i | redirect_i;
  assign target = trap_i ? (trap_smode_i ? STVEC_BASE : MTVEC_BASE) : redirect_pc_i[13:0];

  // An outstanding response already owns one FIFO slot.
  assign credit_ok = (count + CntW'(req_q)) < CntW'(FIFO_DEPTH);
  // Keep the address shown during a response cycle inside the responding bank.
  assign bank_hold = req_q && (bank_of(pc_q) != bank_of(last_q));
  // stop_i also blocks issue in its own cycle so nothing new is requested once stopping.
  assign issue = (state_q == FETCH) && !flush && !stop_i && credit_ok && !bank_hold;

  assign mem_addr_o = xlen_t'(issue ? pc_q : last_q);

  assign push   = req_q && !flush;
  assign pop    = instr_valid_o && instr_ready_i && !flush;
  assign wentry = '{instr: mem_rdata_i, pc: xlen_t'(last_q)};

  clic_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .valid_o (instr_valid_o),
    .rdata_o (head),
    .count_o (count)
  );

  assign instr_o    = head.instr;
  assign instr_pc_o = head.pc;
  assign busy_o     = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= BOOT_ADDR;
      last_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      req_q <= issue;
      if (issue) begin
        last_q <= pc_q;
        pc_q   <= pc_q + 14'd1;
      end
      if (flush) begin
        state_q <= FETCH;
        pc_q    <= target;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i) begin
              state_q <= FETCH;
              pc_q    <= BOOT_ADDR;
            end
          end
          FETCH: if (stop_i) state_q <= DRAIN;
          DRAIN: if ((count == '0) && !req_q) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef CLIC_FETCH_ASSERT_EN
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (count != CntW'(FIFO_DEPTH)));
  a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_valid_o && !instr_ready_i && !flush) |=> ($stable(instr_o) && $stable(instr_pc_o)));
  a_resp_bank: assert property (@(posedge clk_i) disable iff (!rst_ni)
    issue |=> (flush || (bank_of(mem_addr_o[13:0]) == $past(bank_of(mem_addr_o[13:0])))));
  a_addr_upper: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_addr_o[XLEN-1:14] == '0);
`else
  // Default build carries no checkers.
`endif

endmodule

// File: tb/tb_clic_fetch_ctrl.sv
// Self-checking bench for clic_fetch_ctrl: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_clic_fetch_ctrl;
  import clic_tb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, stop, trap, smode, redir, ready;
  logic [31:0]  rpc, mem_addr, mem_rdata, instr, ipc;
  logic         valid, busy;

  logic [31:0]  mem [16384];

  clic_fetch_ctrl #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .stop_i        (stop),
    .trap_i        (trap),
    .trap_smode_i  (smode),
    .redirect_i    (redir),
    .redirect_pc_i (rpc),
    .mem_addr_o    (mem_addr),
    .mem_rdata_i   (mem_rdata),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .instr_pc_o    (ipc),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) mem_rdata <= mem[mem_addr[13:0]];

  typedef struct {
    logic [13:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic [13:0] pc;
    logic [31:0] instr;
    int          cyc;
  } pop_t;

  ent_t        m_q[$];
  pop_t        plog[$];
  int          m_mode;   // 0 idle, 1 fetching, 2 draining
  logic [13:0] m_pc, m_last;
  bit          m_pend;
  int          cyc;
  int          n_checks, n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode = 0;
    m_pc   = 14'h0000;
    m_last = 14'h0000;
    m_pend = 1'b0;
  endtask

  // One clock cycle: apply inputs after the falling edge, compare, advance the model.
  task automatic drive(input bit st, input bit sp, input bit tr, input bit sm, input bit rd,
                       input logic [31:0] rp, input bit rdy);
    bit          exp_valid, flush, iss, was_empty, old_pend;
    int          occ;
    logic [31:0] exp_pc, exp_instr;
    start = st; stop = sp; trap = tr; smode = sm; redir = rd; rpc = rp; ready = rdy;
    #1;
    exp_valid = (m_q.size() > 0);
    exp_pc    = 32'h0;
    exp_instr = 32'h0;
    if (exp_valid) begin
      exp_pc    = {18'h0, m_q[0].pc};
      exp_instr = m_q[0].instr;
    end
    check_eq("valid", {31'h0, valid}, {31'h0, exp_valid});
    check_eq("instr_pc", ipc, exp_pc);
    check_eq("instr", instr, exp_instr);
    check_eq("busy", {31'h0, busy}, {31'h0, (m_mode != 0)});
    flush = tr | rd;
    occ   = m_q.size() + int'(m_pend);
    iss   = (m_mode == 1) && !flush && !sp && (occ < DEPTH)
            && !(m_pend && (m_pc[13:12] != m_last[13:12]));
    check_eq("mem_addr", mem_addr, {18'h0, iss ? m_pc : m_last});
    if (flush) begin
      m_q.delete();
      m_pend = 1'b0;
      m_pc   = tr ? (sm ? 14'h2000 : 14'h1000) : rp[13:0];
      m_mode = 1;
    end else begin
      was_empty = (m_q.size() == 0);
      old_pend  = m_pend;
      if (!was_empty && rdy) begin
        plog.push_back('{pc: m_q[0].pc, instr: m_q[0].instr, cyc: cyc});
        void'(m_q.pop_front());
      end
      if (m_pend) m_q.push_back('{pc: m_last, instr: mem[m_last]});
      if (iss) begin
        m_last = m_pc;
        m_pc   = m_pc + 14'd1;
      end
      m_pend = iss;
      case (m_mode)
        0: if (st) begin m_mode = 1; m_pc = 14'h0000; end
        1: if (sp) m_mode = 2;
        default: if (was_empty && !old_pend) m_mode = 0;
      endcase
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 32'h0, rdy);
  endtask

  int base, c0, fell;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    rst_n = 1'b0;
    start = 0; stop = 0; trap = 0; smode = 0; redir = 0; rpc = 0; ready = 1;
    for (int i = 0; i < 16384; i++) mem[i] = {2'b00, i[13:0], 16'($urandom)};
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_valid", {31'h0, valid}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_addr", mem_addr, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_pc", ipc, 32'h0);
    rst_n = 1'b1;
    idle_cycles(2, 1);

    // 1: boot fetch, first valid three cycles after start, then one per cycle.
    base = plog.size(); c0 = cyc;
    drive(1, 0, 0, 0, 0, 32'h0, 1);
    idle_cycles(12, 1);
    check_eq("t1_count", {31'h0, (plog.size() - base) >= 8}, 32'h1);
    if (plog.size() - base >= 8)
      for (int k = 0; k < 8; k++) begin
        check_eq("t1_pc", {18'h0, plog[base+k].pc}, k);
        check_eq("t1_cyc", plog[base+k].cyc - c0, 3 + k);
      end

    // 2: backpressure holds the FIFO, then drains with no gaps or duplicates.
    idle_cycles(10, 0);
    base = plog.size();
    idle_cycles(12, 1);
    check_eq("t2_count", {31'h0, (plog.size() - base) >= DEPTH}, 32'h1);
    for (int k = base + 1; k < plog.size(); k++)
      check_eq("t2_seq", {18'h0, plog[k].pc}, {18'h0, plog[k-1].pc + 14'd1});

    // 3: bank crossing costs one bubble; 0x1000 carries bank-1 word 0.
    drive(0, 0, 0, 0, 1, 32'h0000_0FFE, 1);
    base = plog.size(); c0 = cyc;
    idle_cycles(10, 1);
    check_eq("t3_count", {31'h0, (plog.size() - base) >= 4}, 32'h1);
    if (plog.size() - base >= 4) begin
      check_eq("t3_pc0", {18'h0, plog[base].pc}, 32'h0FFE);
      check_eq("t3_pc2", {18'h0, plog[base+2].pc}, 32'h1000);
      check_eq("t3_gap1", plog[base+1].cyc - plog[base].cyc, 1);
      check_eq("t3_bubble", plog[base+2].cyc - plog[base+1].cyc, 2);
      check_eq("t3_data", plog[base+2].instr, mem[14'h1000]);
    end

    // 4: S-mode trap with a full FIFO flushes and restarts at STVEC_BASE.
    idle_cycles(8, 0);
    drive(0, 0, 1, 1, 0, 32'h0, 0);
    check_eq("t4_c1", {31'h0, valid}, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    check_eq("t4_c2", {31'h0, valid}, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    check_eq("t4_c3", {31'h0, valid}, 32'h1);
    check_eq("t4_pc", ipc, 32'h2000);

    // 5: trap beats redirect, then a plain redirect lands on its target.
    drive(0, 0, 1, 0, 1, 32'h0000_0040, 1);
    idle_cycles(2, 1);
    check_eq("t5_trap_pc", ipc, 32'h1000);
    idle_cycles(3, 1);
    drive(0, 0, 0, 0, 1, 32'h0000_0040, 1);
    idle_cycles(2, 1);
    check_eq("t5_redir_v", {31'h0, valid}, 32'h1);
    check_eq("t5_redir_pc", ipc, 32'h0040);

    // 6: stop with three queued delivers three, then goes idle; then reset mid-fetch.
    idle_cycles(8, 0);
    idle_cycles(1, 1);
    drive(0, 1, 0, 0, 0, 32'h0, 0);
    base = plog.size(); fell = 0;
    for (int i = 0; i < 10 && !fell; i++) begin
      drive(0, 0, 0, 0, 0, 32'h0, 1);
      if (!busy) fell = 1;
    end
    check_eq("t6_delivered", plog.size() - base, 3);
    check_eq("t6_busy", {31'h0, busy}, 32'h0);
    drive(1, 0, 0, 0, 0, 32'h0, 0);
    idle_cycles(4, 0);
    rst_n = 1'b0;
    #1;
    check_eq("rst2_valid", {31'h0, valid}, 32'h0);
    check_eq("rst2_busy", {31'h0, busy}, 32'h0);
    check_eq("rst2_addr", mem_addr, 32'h0);
    check_eq("rst2_instr", instr, 32'h0);
    check_eq("rst2_pc", ipc, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 39) == 0, $urandom, $urandom_range(0, 9) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
